// File: rtl/lifo_stack_gen_pkg.sv
// ---------------------------------------------------------------------------
// lifo_stack_gen_pkg
// Shared definitions for the LIFO stack: the stack-operation encodings used by
// the stack-pointer/control decode, and a constant-evaluable ceil(log2()).
// No ports (package).
// ---------------------------------------------------------------------------
package lifo_stack_gen_pkg;

    // Operation resolved from the push/pop request pair for one cycle.
    typedef enum logic [1:0] {
        OP_NONE = 2'd0,  // idle
        OP_PUSH = 2'd1,  // push only (also push+pop on an empty stack)
        OP_POP  = 2'd2,  // pop only
        OP_REPL = 2'd3   // push+pop on a non-empty stack: overwrite the top
    } lifo_op_e;

    // ceil(log2(value)); returns 0 for value <= 1. Usable in parameter context.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : lifo_stack_gen_pkg

// File: rtl/lifo_stack_gen_regfile.sv
// ---------------------------------------------------------------------------
// lifo_stack_gen_regfile
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous (combinational) read port.
// Ports:
//   clock  in   rising-edge write clock
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// ---------------------------------------------------------------------------
module lifo_stack_gen_regfile #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             clock,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset; stale words are never visible because the
    // top level masks the read port whenever the stack is empty, and leaving
    // storage unreset lets it map onto plain registers or distributed RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : lifo_stack_gen_regfile

// File: rtl/lifo_stack_gen.sv
// ---------------------------------------------------------------------------
// lifo_stack_gen
// Parametrised LIFO stack with full/empty/count status, one-cycle overflow and
// underflow pulses, and a replace-top mode for simultaneous push+pop.
// Optional high-water mark enabled by defining LIFO_WATERMARK_EN.
// Ports:
//   clock      in   system clock, all state on the rising edge
//   reset      in   synchronous, active-high; wins over push/pop
//   push       in   push data_in this cycle
//   pop        in   pop the top entry this cycle
//   data_in    in   word to push
//   data_out   out  current top of stack, zero when empty (no latency)
//   full       out  count == DEPTH
//   empty      out  count == 0
//   count      out  entries held
//   overflow   out  1-cycle pulse: push refused (full, no pop)
//   underflow  out  1-cycle pulse: pop refused (empty)
//   max_depth  out  high-water mark (LIFO_WATERMARK_EN only)
// ---------------------------------------------------------------------------
module lifo_stack_gen
    import lifo_stack_gen_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
`ifdef LIFO_WATERMARK_EN
    ,
    output logic [CW-1:0]    max_depth
`endif
);

    localparam int            AW     = clog2(DEPTH);
    localparam logic [CW-1:0] SP_MAX = CW'(DEPTH);

    logic [CW-1:0]    sp;
    logic [CW-1:0]    sp_next;
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    waddr;
    logic             we;
    logic             overflow_next;
    logic             underflow_next;
    logic [WIDTH-1:0] rdata;
    lifo_op_e         op;

    // Status decoded straight from sp so it moves in the same cycle as sp.
    assign empty    = (sp == '0);
    assign full     = (sp == SP_MAX);
    assign count    = sp;
    assign top_addr = AW'(sp - CW'(1));
    assign data_out = empty ? '0 : rdata;

    // NOTE: every signal written here gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        op             = OP_NONE;
        sp_next        = sp;
        we             = 1'b0;
        waddr          = AW'(sp);
        overflow_next  = 1'b0;
        // A pop against an empty stack is refused, whether alone or paired
        // with a push (the push part still proceeds).
        underflow_next = pop && empty;

        if (push && pop && !empty) begin
            op = OP_REPL;
        end else if (push) begin
            op = OP_PUSH;
        end else if (pop) begin
            op = OP_POP;
        end

        case (op)
            OP_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    sp_next = sp + CW'(1);
                end else begin
                    overflow_next = 1'b1;
                end
            end
            OP_POP: begin
                if (!empty) begin
                    sp_next = sp - CW'(1);
                end
            end
            OP_REPL: begin
                // Overwrite the top in place; legal even when full.
                we    = 1'b1;
                waddr = top_addr;
            end
            default: ;
        endcase
    end

    lifo_stack_gen_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_regfile (
        .clock (clock),
        .we    (we && !reset),
        .waddr (waddr),
        .wdata (data_in),
        .raddr (top_addr),
        .rdata (rdata)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_next;
            overflow  <= overflow_next;
            underflow <= underflow_next;
        end
    end

`ifdef LIFO_WATERMARK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            max_depth <= '0;
        end else if (sp_next > max_depth) begin
            max_depth <= sp_next;
        end
    end
`endif

endmodule : lifo_stack_gen

// File: tb/tb_lifo_stack_gen.sv
// ---------------------------------------------------------------------------
// tb_lifo_stack_gen
// Directed, self-checking bench for lifo_stack_gen (WIDTH=8, DEPTH=4).
// A queue-based reference stack predicts the state after each cycle; the
// predictions are queued as expectations and compared once the DUT has
// updated. Define LIFO_WATERMARK_EN to also cover max_depth.
// ---------------------------------------------------------------------------
module tb_lifo_stack_gen;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             push  = 1'b0;
    logic             pop   = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
`ifdef LIFO_WATERMARK_EN
    logic [CW-1:0]    max_depth;
`endif

    lifo_stack_gen #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .data_in   (data_in),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`ifdef LIFO_WATERMARK_EN
        ,
        .max_depth (max_depth)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t          sb_q[$];
    logic [WIDTH-1:0] mdl[$];
    logic             exp_ovf;
    logic             exp_unf;
    int               exp_max;
    int               n_tests;
    int               n_fail;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] observe(input string tag);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        if (tag == "data_out")       v = 32'(data_out);
        else if (tag == "count")     v = 32'(count);
        else if (tag == "empty")     v = 32'(empty);
        else if (tag == "full")      v = 32'(full);
        else if (tag == "overflow")  v = 32'(overflow);
        else if (tag == "underflow") v = 32'(underflow);
`ifdef LIFO_WATERMARK_EN
        else if (tag == "max_depth") v = 32'(max_depth);
`endif
        return v;
    endfunction

    // Queue the reference model's view of the state after the last edge.
    task automatic expect_model();
        int n;
        n = mdl.size();
        sb_q.push_back('{"count",     32'(n)});
        sb_q.push_back('{"empty",     32'(n == 0)});
        sb_q.push_back('{"full",      32'(n == DEPTH)});
        sb_q.push_back('{"data_out",  (n > 0) ? 32'(mdl[n-1]) : 32'd0});
        sb_q.push_back('{"overflow",  32'(exp_ovf)});
        sb_q.push_back('{"underflow", 32'(exp_unf)});
`ifdef LIFO_WATERMARK_EN
        sb_q.push_back('{"max_depth", 32'(exp_max)});
`endif
    endtask

    task automatic drain();
        expect_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(e.tag, observe(e.tag), e.value);
        end
    endtask

    // One clock cycle with the given request; outputs sampled 1 ns after the edge.
    task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d);
        int n;
        n       = mdl.size();
        exp_ovf = p && !q && (n == DEPTH);
        exp_unf = q && (n == 0);
        if (p && q && n > 0) begin
            mdl[n-1] = d;
        end else if (p) begin
            if (n < DEPTH) mdl.push_back(d);
        end else if (q && n > 0) begin
            void'(mdl.pop_back());
        end
        if (mdl.size() > exp_max) exp_max = mdl.size();

        push    = p;
        pop     = q;
        data_in = d;
        @(posedge clock);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        expect_model();
        drain();
    endtask

    // Reset cycle, optionally with a push held high to show reset wins.
    task automatic reset_step(input logic p);
        reset   = 1'b1;
        push    = p;
        data_in = 8'hEE;
        @(posedge clock);
        #1;
        reset = 1'b0;
        push  = 1'b0;
        mdl.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_max = 0;
        expect_model();
        drain();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_max = 0;

        // Reset state.
        reset_step(1'b0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);

        // 1: reset in the middle of a sequence, with push asserted alongside.
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        reset_step(1'b1);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_dout",  32'(data_out), 32'd0);

        // 2: fill to full, then a refused push.
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 8'h44);
        check("full_flag", 32'(full), 32'd1);
        check("full_top",  32'(data_out), 32'h44);
        step(1'b1, 1'b0, 8'h55);
        check("ovf_pulse", 32'(overflow), 32'd1);
        check("ovf_top",   32'(data_out), 32'h44);
        step(1'b0, 1'b0, 8'h00);
        check("ovf_clear", 32'(overflow), 32'd0);

        // 3: drain, then a refused pop.
        step(1'b0, 1'b1, 8'h00);
        check("pop1_top", 32'(data_out), 32'h33);
        step(1'b0, 1'b1, 8'h00);
        check("pop2_top", 32'(data_out), 32'h22);
        step(1'b0, 1'b1, 8'h00);
        check("pop3_top", 32'(data_out), 32'h11);
        step(1'b0, 1'b1, 8'h00);
        check("pop4_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check("unf_pulse", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check("unf_clear", 32'(underflow), 32'd0);

        // 4: replace top on a partly filled stack.
        step(1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 8'h99);
        check("repl_count", 32'(count), 32'd2);
        check("repl_top",   32'(data_out), 32'h99);
        step(1'b0, 1'b1, 8'h00);
        check("repl_pop",   32'(data_out), 32'h11);
        step(1'b0, 1'b1, 8'h00);

        // 5: push+pop when empty (push proceeds, pop flagged) and when full.
        step(1'b1, 1'b1, 8'h7A);
        check("ppe_top", 32'(data_out), 32'h7A);
        check("ppe_unf", 32'(underflow), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h01);
        step(1'b1, 1'b0, 8'h02);
        step(1'b1, 1'b0, 8'h03);
        step(1'b1, 1'b1, 8'h05);
        check("ppf_count", 32'(count), 32'd4);
        check("ppf_top",   32'(data_out), 32'h05);
        check("ppf_ovf",   32'(overflow), 32'd0);
        step(1'b0, 1'b1, 8'h00);
        check("ppf_below", 32'(data_out), 32'h02);

`ifdef LIFO_WATERMARK_EN
        // 6: high-water mark holds the peak and clears only on reset.
        reset_step(1'b0);
        step(1'b1, 1'b0, 8'hA1);
        step(1'b1, 1'b0, 8'hA2);
        step(1'b1, 1'b0, 8'hA3);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'hA4);
        check("wm_peak", 32'(max_depth), 32'd3);
        reset_step(1'b0);
        check("wm_reset", 32'(max_depth), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lifo_stack_gen
